// File: rtl/instr_decode.sv
// Instruction decoder for a small MAC sequencer.
// Decodes one 24-bit program word per cycle into a combinational loop
// request for the sequencer and registered datapath controls.
// A two-state machine (RUN/HALT) gates all activity. HALT is left only
// through reset.
module instr_decode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] instr,
  output logic        loop_we,
  output logic [7:0]  loop_iter,
  output logic [7:0]  loop_size,
  output logic        mac_en,
  output logic        acc_clr,
  output logic [7:0]  coef_addr,
  output logic [7:0]  data_addr,
  output logic        out_we,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOOP  = 4'h1;
  localparam logic [3:0] OP_CLR   = 4'h2;
  localparam logic [3:0] OP_MAC   = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_PTR   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic [7:0] coef_ptr_q, data_ptr_q;
  logic [7:0] coef_ptr_d, data_ptr_d;
  logic [7:0] coef_addr_d, data_addr_d;
  logic       mac_en_d, acc_clr_d, out_we_d, illegal_d;

  assign opcode = instr[23:20];

  // Loop-register write goes straight to the sequencer in the same cycle.
  // It is gated by reset_n so nothing is written while reset is held.
  assign loop_we   = reset_n && (state_q == ST_RUN) && (opcode == OP_LOOP);
  assign loop_iter = instr[15:8];
  assign loop_size = instr[7:0];
  assign halted    = (state_q == ST_HALT);

  // Next-state and next-control decode for the current instruction word.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch can be inferred.
    state_d     = state_q;
    mac_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    out_we_d    = 1'b0;
    illegal_d   = illegal;
    coef_addr_d = coef_addr;
    data_addr_d = data_addr;
    coef_ptr_d  = coef_ptr_q;
    data_ptr_d  = data_ptr_q;

    if (state_q == ST_RUN) begin
      case (opcode)
        OP_NOP, OP_LOOP: ;
        OP_CLR:   acc_clr_d = 1'b1;
        OP_STORE: out_we_d  = 1'b1;
        OP_MAC: begin
          mac_en_d = 1'b1;
          if (instr[17]) begin
            // Pointer mode: issue the current pointers, then optionally
            // post-increment them. The 8-bit add wraps 0xFF to 0x00.
            coef_addr_d = coef_ptr_q;
            data_addr_d = data_ptr_q;
            if (instr[16]) begin
              coef_ptr_d = coef_ptr_q + 8'd1;
              data_ptr_d = data_ptr_q + 8'd1;
            end
          end else begin
            coef_addr_d = instr[15:8];
            data_addr_d = instr[7:0];
          end
        end
        OP_PTR: begin
          coef_ptr_d = instr[15:8];
          data_ptr_d = instr[7:0];
        end
        OP_HALT:  state_d   = ST_HALT;
        default:  illegal_d = 1'b1;
      endcase
    end
  end

  // State register and registered controls, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      mac_en     <= 1'b0;
      acc_clr    <= 1'b0;
      out_we     <= 1'b0;
      illegal    <= 1'b0;
      coef_addr  <= 8'h00;
      data_addr  <= 8'h00;
      coef_ptr_q <= 8'h00;
      data_ptr_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values computed by the decode block.
      state_q    <= state_d;
      mac_en     <= mac_en_d;
      acc_clr    <= acc_clr_d;
      out_we     <= out_we_d;
      illegal    <= illegal_d;
      coef_addr  <= coef_addr_d;
      data_addr  <= data_addr_d;
      coef_ptr_q <= coef_ptr_d;
      data_ptr_q <= data_ptr_d;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode.
// Tests drive one word per cycle on the falling edge and push the registered
// outputs they expect after the next rising edge. A monitor pops and compares
// those expectations 1 ns after each rising edge. Combinational and
// asynchronous behaviour is compared inline within each test.
module tb_instr_decode;

  logic        clk;
  logic        reset_n;
  logic [23:0] instr;
  logic        loop_we;
  logic [7:0]  loop_iter, loop_size;
  logic        mac_en, acc_clr, out_we, halted, illegal;
  logic [7:0]  coef_addr, data_addr;

  typedef struct packed {
    logic       mac_en;
    logic       acc_clr;
    logic       out_we;
    logic [7:0] coef_addr;
    logic [7:0] data_addr;
    logic       halted;
    logic       illegal;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  instr_decode dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .loop_we   (loop_we),
    .loop_iter (loop_iter),
    .loop_size (loop_size),
    .mac_en    (mac_en),
    .acc_clr   (acc_clr),
    .coef_addr (coef_addr),
    .data_addr (data_addr),
    .out_we    (out_we),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic m, input logic c, input logic w,
                              input logic [7:0] ca, input logic [7:0] da,
                              input logic h, input logic il);
    exp_t e;
    e.mac_en = m; e.acc_clr = c; e.out_we = w;
    e.coef_addr = ca; e.data_addr = da; e.halted = h; e.illegal = il;
    return e;
  endfunction

  // Scoreboard monitor: compares registered outputs against queued expectations.
  always @(posedge clk) begin
    exp_t  e;
    exp_t  obs;
    string n;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      obs = '{mac_en, acc_clr, out_we, coef_addr, data_addr, halted, illegal};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got mac/clr/we=%b%b%b coef=%h data=%h halt=%b ill=%b, want mac/clr/we=%b%b%b coef=%h data=%h halt=%b ill=%b",
                 n, obs.mac_en, obs.acc_clr, obs.out_we, obs.coef_addr, obs.data_addr, obs.halted, obs.illegal,
                 e.mac_en, e.acc_clr, e.out_we, e.coef_addr, e.data_addr, e.halted, e.illegal);
      end
    end
  end

  // Present one word for one cycle and queue the outputs expected after it.
  task automatic apply(input logic [23:0] w, input exp_t e, input string n);
    @(negedge clk);
    instr = w;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    instr   = 24'h10_0403;
    #1;
    checks++;
    if ({mac_en, acc_clr, out_we, halted, illegal, coef_addr, data_addr} !== 21'h0) begin
      errors++;
      $display("FAIL reset_values: got mac/clr/we/halt/ill=%b%b%b%b%b coef=%h data=%h, want all 0",
               mac_en, acc_clr, out_we, halted, illegal, coef_addr, data_addr);
    end
    checks++;
    if (loop_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_loop_we: got %b want 0", loop_we);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    instr   = 24'h00_0000;
  endtask

  task automatic test_loop;
    @(negedge clk);
    instr = 24'h10_0403;
    exp_q.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    name_q.push_back("loop_regs");
    #1;
    checks++;
    if ({loop_we, loop_iter, loop_size} !== {1'b1, 8'h04, 8'h03}) begin
      errors++;
      $display("FAIL loop_decode: got we=%b iter=%h size=%h, want we=1 iter=04 size=03",
               loop_we, loop_iter, loop_size);
    end
    @(posedge clk);
    @(negedge clk);
    instr = 24'h00_0000;
    exp_q.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    name_q.push_back("nop_after_loop");
    #1;
    checks++;
    if (loop_we !== 1'b0) begin
      errors++;
      $display("FAIL loop_we_nop: got %b want 0", loop_we);
    end
    @(posedge clk);
  endtask

  task automatic test_mac_direct;
    apply(24'h30_2A07, mk(1, 0, 0, 8'h2A, 8'h07, 0, 0), "mac_direct");
    apply(24'h00_0000, mk(0, 0, 0, 8'h2A, 8'h07, 0, 0), "mac_direct_hold");
  endtask

  task automatic test_ptr_autoinc;
    apply(24'h50_10FE, mk(0, 0, 0, 8'h2A, 8'h07, 0, 0), "ptr_load");
    apply(24'h33_0000, mk(1, 0, 0, 8'h10, 8'hFE, 0, 0), "mac_ptr_0");
    apply(24'h33_0000, mk(1, 0, 0, 8'h11, 8'hFF, 0, 0), "mac_ptr_1");
    apply(24'h33_0000, mk(1, 0, 0, 8'h12, 8'h00, 0, 0), "mac_ptr_wrap");
    apply(24'h32_0000, mk(1, 0, 0, 8'h13, 8'h01, 0, 0), "mac_ptr_noinc_0");
    apply(24'h32_0000, mk(1, 0, 0, 8'h13, 8'h01, 0, 0), "mac_ptr_noinc_1");
    apply(24'h00_0000, mk(0, 0, 0, 8'h13, 8'h01, 0, 0), "mac_ptr_hold");
  endtask

  task automatic test_back_to_back;
    apply(24'h20_0000, mk(0, 1, 0, 8'h13, 8'h01, 0, 0), "clr_pulse");
    apply(24'h40_0000, mk(0, 0, 1, 8'h13, 8'h01, 0, 0), "store_pulse");
    apply(24'h70_0000, mk(0, 0, 0, 8'h13, 8'h01, 0, 1), "illegal_set");
    for (int i = 0; i < 20; i++)
      apply(24'h00_0000, mk(0, 0, 0, 8'h13, 8'h01, 0, 1), "illegal_sticky");
  endtask

  task automatic test_halt;
    apply(24'hF0_0000, mk(0, 0, 0, 8'h13, 8'h01, 1, 1), "halt_enter");
    @(negedge clk);
    instr = 24'h10_0403;
    exp_q.push_back(mk(0, 0, 0, 8'h13, 8'h01, 1, 1));
    name_q.push_back("halt_loop");
    #1;
    checks++;
    if (loop_we !== 1'b0) begin
      errors++;
      $display("FAIL halt_loop_we: got %b want 0", loop_we);
    end
    @(posedge clk);
    apply(24'h30_2A07, mk(0, 0, 0, 8'h13, 8'h01, 1, 1), "halt_mac");
    apply(24'h50_55AA, mk(0, 0, 0, 8'h13, 8'h01, 1, 1), "halt_ptr");
    apply(24'h33_0000, mk(0, 0, 0, 8'h13, 8'h01, 1, 1), "halt_mac_ptr");
    apply(24'h20_0000, mk(0, 0, 0, 8'h13, 8'h01, 1, 1), "halt_clr");
    // Reset pulse out of HALT; LOOP word on the bus must not write while held.
    @(negedge clk);
    reset_n = 1'b0;
    instr   = 24'h10_0403;
    #1;
    checks++;
    if ({mac_en, acc_clr, out_we, halted, illegal, coef_addr, data_addr, loop_we} !== 22'h0) begin
      errors++;
      $display("FAIL halt_reset: got mac/clr/we/halt/ill=%b%b%b%b%b coef=%h data=%h loop_we=%b, want all 0",
               mac_en, acc_clr, out_we, halted, illegal, coef_addr, data_addr, loop_we);
    end
    @(negedge clk);
    reset_n = 1'b1;
    instr   = 24'h00_0000;
    exp_q.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    name_q.push_back("after_release");
    @(posedge clk);
    // Pointers must also have been cleared by the reset.
    apply(24'h33_0000, mk(1, 0, 0, 8'h00, 8'h00, 0, 0), "ptr_after_reset_0");
    apply(24'h33_0000, mk(1, 0, 0, 8'h01, 8'h01, 0, 0), "ptr_after_reset_1");
    apply(24'h00_0000, mk(0, 0, 0, 8'h01, 8'h01, 0, 0), "ptr_after_reset_nop");
  endtask

  task automatic test_async_reset;
    apply(24'h30_AA55, mk(1, 0, 0, 8'hAA, 8'h55, 0, 0), "mac_before_async");
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mac_en, coef_addr, data_addr} !== 17'h0) begin
      errors++;
      $display("FAIL async_reset: got mac_en=%b coef=%h data=%h, want 0 00 00",
               mac_en, coef_addr, data_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    instr   = 24'h00_0000;
    exp_q.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    name_q.push_back("async_release");
    @(posedge clk);
    apply(24'h00_0000, mk(0, 0, 0, 8'h00, 8'h00, 0, 0), "async_nop");
  endtask

  initial begin
    test_reset;
    test_loop;
    test_mac_direct;
    test_ptr_autoinc;
    test_back_to_back;
    test_halt;
    test_async_reset;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset_n  input  1  asynchronous active-low reset; asserting forces reset state immediately; release is synchronous to clk.
REQ-003 instr  input  24  program-memory word at the sequencer's current addr; combinational-read memory, valid in the same cycle as addr.
REQ-004 loop_we  output  1  loop-register write enable to the program sequencer; combinational.
REQ-005 loop_iter  output  8  loop iteration count to the sequencer; combinational, equals instr[15:8].
REQ-006 loop_size  output  8  loop body size to the sequencer; combinational, equals instr[7:0].
REQ-007 mac_en  output  1  registered; MAC datapath enable.
REQ-008 acc_clr  output  1  registered; clear accumulator.
REQ-009 coef_addr  output  8  registered; coefficient-memory address.
REQ-010 data_addr  output  8  registered; sample-buffer address.
REQ-011 out_we  output  1  registered; write accumulator to output port.
REQ-012 halted  output  1  registered; high while in HALT state.
REQ-013 illegal  output  1  registered; sticky, set on any undefined opcode.

Function
REQ-014 Opcode = instr[23:20]; 0 NOP, 1 LOOP, 2 CLR, 3 MAC, 4 STORE, 5 PTR, F HALT; 6-E undefined.
REQ-015 State machine, two states: RUN (reset state), HALT; RUN->HALT on HALT opcode; HALT exits only via reset.
REQ-016 loop_we = 1 iff state RUN and opcode LOOP; 0 otherwise, including HALT state and during reset.
REQ-017 loop_iter and loop_size pass through unconditionally; meaningful only when loop_we = 1.
REQ-018 Registered controls have 1-cycle latency: instruction presented in cycle n drives mac_en/acc_clr/out_we/coef_addr/data_addr in cycle n+1.
REQ-019 mac_en, acc_clr, out_we are single-cycle pulses; each deasserts the cycle after any non-matching instruction.
REQ-020 CLR: acc_clr = 1 next cycle; all other pulses 0.
REQ-021 STORE: out_we = 1 next cycle; all other pulses 0.
REQ-022 MAC, instr[17] = 0: mac_en = 1, coef_addr = instr[15:8], data_addr = instr[7:0].
REQ-023 MAC, instr[17] = 1: mac_en = 1, coef_addr = coef_ptr, data_addr = data_ptr (pointer values before update).
REQ-024 MAC, instr[17] = 1 and instr[16] = 1: coef_ptr and data_ptr each post-increment by 1, modulo 256 (0xFF wraps to 0x00).
REQ-025 PTR: coef_ptr <= instr[15:8], data_ptr <= instr[7:0]; no pulses; a MAC in the next cycle uses the new values.
REQ-026 coef_addr and data_addr hold their last value on non-MAC instructions.
REQ-027 Undefined opcode: treated as NOP; illegal set next cycle, held until reset.
REQ-028 HALT: halted = 1 from next cycle; in HALT all pulses 0, pointers and addresses frozen, instr ignored.
REQ-029 LOOP, NOP: no pulses, no pointer change.

Reset
REQ-030 reset_n low: state RUN; mac_en, acc_clr, out_we, halted, illegal = 0; coef_addr, data_addr, coef_ptr, data_ptr = 0x00.
REQ-031 Reset asserted mid-operation (including in HALT) aborts immediately; no pulse is emitted in the cycle after release unless the instruction in that cycle commands one.

Verification
REQ-032 instr = 0x10_0403 (LOOP iter 4 size 3) in RUN -> same cycle loop_we = 1, loop_iter = 0x04, loop_size = 0x03; next instr NOP -> loop_we = 0.
REQ-033 PTR 0x50_10FE, then MAC 0x33_0000 three times -> (coef_addr, data_addr) = (10,FE), (11,FF), (12,00) on the following cycles; mac_en high three cycles.
REQ-034 MAC 0x30_2A07 -> next cycle mac_en = 1, coef_addr = 0x2A, data_addr = 0x07; then NOP -> mac_en = 0, addresses held.
REQ-035 CLR, STORE, opcode 0x7 -> acc_clr pulse, then out_we pulse, then illegal = 1 and stays 1 through 20 NOPs.
REQ-036 HALT then LOOP and MAC words -> halted = 1, loop_we = 0, mac_en = 0; reset_n pulsed low -> halted = 0, all outputs at reset values.
REQ-037 reset_n asserted asynchronously between edges during a MAC pulse -> mac_en and addresses go to 0 without waiting for clk.
